// File: rtl/data_mem_subword.sv
// -----------------------------------------------------------------------------
// data_mem_subword
//   Byte-addressed MEM-stage data memory with byte/half/word loads and stores.
//   Stores are synchronous and per-lane masked. Loads are combinational and are
//   sign- or zero-extended. Misaligned, out-of-range and illegal-size accesses
//   are suppressed. The first such fault is held in a sticky capture register,
//   and a saturating counter counts every fault.
//
//   Optional build macro: DMEM_PARITY_EN
//     Defined   : one even-parity bit per byte lane. ParityInjM flips the stored
//                 bit on write. Legal loads with RE=1 report a mismatch on
//                 ParityErrM, and the mismatch is captured with cause bit3.
//     Undefined : no parity storage. ParityErrM is tied to 0.
//
// Ports
//   CLK         clock
//   rst         asynchronous reset, active low
//   WE / RE     store enable / load enable (RE only qualifies fault capture)
//   ALUOutM     byte address
//   WriteDataM  right-aligned store data
//   SizeM       00 byte, 01 half, 10 word, 11 illegal
//   LoadUnsM    1 = zero-extend loads, 0 = sign-extend
//   ParityInjM  invert the stored parity of the written lanes
//   ReadDataM   extended load data (0 for an illegal access)
//   AccErrM     the current access is illegal (combinational)
//   ParityErrM  parity mismatch on the current load (combinational)
//   FaultValid, FaultAddr, FaultCause, FaultWr  sticky first-fault capture
//   FaultCnt    saturating count of faulting accesses
//   FaultClr    clears the capture registers (FaultCnt is not cleared)
// -----------------------------------------------------------------------------
module data_mem_subword #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             WE,
    input  logic             RE,
    input  logic [31:0]      ALUOutM,
    input  logic [31:0]      WriteDataM,
    input  logic [1:0]       SizeM,
    input  logic             LoadUnsM,
    input  logic             ParityInjM,
    output logic [31:0]      ReadDataM,
    output logic             AccErrM,
    output logic             ParityErrM,
    output logic             FaultValid,
    output logic [31:0]      FaultAddr,
    output logic [3:0]       FaultCause,
    output logic             FaultWr,
    output logic [CNT_W-1:0] FaultCnt,
    input  logic             FaultClr
);

    localparam int AW = $clog2(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic uns);
        logic signed [7:0] s;
        s = v;
        return uns ? {24'b0, v} : 32'(s);
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic uns);
        logic signed [15:0] s;
        s = v;
        return uns ? {16'b0, v} : 32'(s);
    endfunction

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          mis, oor, ill, acc_bad, do_store, fault_evt;
    logic [3:0]    lmask;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    assign idx  = ALUOutM[AW+1:2];
    assign lane = ALUOutM[1:0];

    // Legality of the access, independent of WE/RE.
    always_comb begin
        mis = 1'b0;
        case (SizeM)
            2'b01:   mis = lane[0];
            2'b10:   mis = |lane;
            default: mis = 1'b0;
        endcase
    end

    assign oor      = |ALUOutM[31:AW+2];
    assign ill      = (SizeM == 2'b11);
    assign acc_bad  = mis | oor | ill;
    assign AccErrM  = (WE | RE) & acc_bad;
    assign do_store = WE & ~acc_bad;

    // Lane mask is shared by the store path and the parity check on loads.
    // Store data is replicated so every lane sees its own byte at the same
    // offset.
    always_comb begin
        lmask = 4'b0000;
        wdata = WriteDataM;
        case (SizeM)
            2'b00: begin
                lmask = 4'b0001 << lane;
                wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                lmask = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WriteDataM[15:0]}};
            end
            2'b10: begin
                lmask = 4'b1111;
                wdata = WriteDataM;
            end
            default: begin
                lmask = 4'b0000;
                wdata = WriteDataM;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_store) begin
            for (int b = 0; b < 4; b++)
                if (lmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Asynchronous load path. The old word is returned until the write edge.
    assign rword = mem[idx];
    assign rbyte = rword[8*lane +: 8];
    assign rhalf = rword[16*lane[1] +: 16];

    always_comb begin
        ReadDataM = '0;
        if (!acc_bad) begin
            case (SizeM)
                2'b00:   ReadDataM = ext8(rbyte, LoadUnsM);
                2'b01:   ReadDataM = ext16(rhalf, LoadUnsM);
                default: ReadDataM = rword;
            endcase
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par [DEPTH];
    logic [3:0] pmis;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) par[i] <= '0;
        end else if (do_store) begin
            for (int b = 0; b < 4; b++)
                if (lmask[b]) par[idx][b] <= (^wdata[8*b +: 8]) ^ ParityInjM;
        end
    end

    always_comb begin
        pmis = 4'b0000;
        for (int b = 0; b < 4; b++)
            pmis[b] = par[idx][b] ^ (^rword[8*b +: 8]);
    end

    assign ParityErrM = RE & ~acc_bad & |(pmis & lmask);
`else
    logic unused_parinj;
    assign unused_parinj = ParityInjM;
    assign ParityErrM    = 1'b0;
`endif

    assign fault_evt = AccErrM | (ParityErrM & RE);

    // A new fault in the same cycle as FaultClr wins over the clear.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            FaultValid <= 1'b0;
            FaultAddr  <= '0;
            FaultCause <= '0;
            FaultWr    <= 1'b0;
            FaultCnt   <= '0;
        end else begin
            if (fault_evt && (!FaultValid || FaultClr)) begin
                FaultValid <= 1'b1;
                FaultAddr  <= ALUOutM;
                FaultCause <= {ParityErrM & RE, ill, oor, mis};
                FaultWr    <= WE;
            end else if (FaultClr) begin
                FaultValid <= 1'b0;
                FaultAddr  <= '0;
                FaultCause <= '0;
                FaultWr    <= 1'b0;
            end
            if (fault_evt) FaultCnt <= sat_inc(FaultCnt);
        end
    end

endmodule

// File: tb/tb_data_mem_subword.sv
module tb_data_mem_subword;

    localparam int DEPTH = 64;
    localparam int CNT_W = 8;
    localparam int NB    = 4 * DEPTH;

    logic             CLK;
    logic             rst;
    logic             WE, RE;
    logic [31:0]      ALUOutM, WriteDataM;
    logic [1:0]       SizeM;
    logic             LoadUnsM, ParityInjM, FaultClr;
    logic [31:0]      ReadDataM;
    logic             AccErrM, ParityErrM, FaultValid, FaultWr;
    logic [31:0]      FaultAddr;
    logic [3:0]       FaultCause;
    logic [CNT_W-1:0] FaultCnt;

    data_mem_subword #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .rst(rst), .WE(WE), .RE(RE), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .SizeM(SizeM), .LoadUnsM(LoadUnsM),
        .ParityInjM(ParityInjM), .ReadDataM(ReadDataM), .AccErrM(AccErrM),
        .ParityErrM(ParityErrM), .FaultValid(FaultValid), .FaultAddr(FaultAddr),
        .FaultCause(FaultCause), .FaultWr(FaultWr), .FaultCnt(FaultCnt),
        .FaultClr(FaultClr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a flat byte array plus a per-byte "parity corrupted" flag.
    logic [7:0]       mb   [NB];
    logic             mbad [NB];
    logic             m_fv, m_fw;
    logic [31:0]      m_fa;
    logic [3:0]       m_fc;
    logic [CNT_W-1:0] m_cnt;

    int          checks, failures;
    logic [31:0] last_rd;
    logic        last_par;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            mb[i]   = 8'h00;
            mbad[i] = 1'b0;
        end
        m_fv = 0; m_fw = 0; m_fa = 0; m_fc = 0; m_cnt = 0;
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic is_legal(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd3) return 1'b0;
        if (a >= 32'(NB)) return 1'b0;
        return (a % nbytes(s)) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                               input logic uns);
        logic [31:0] v;
        int n;
        if (!is_legal(a, s)) return 32'h0;
        n = nbytes(s);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[int'(a) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    function automatic logic model_par(input logic re, input logic [31:0] a, input logic [1:0] s);
        logic p;
        p = 1'b0;
`ifdef DMEM_PARITY_EN
        if (re && is_legal(a, s))
            for (int i = 0; i < nbytes(s); i++) p = p | mbad[int'(a) + i];
`endif
        return p;
    endfunction

    // One bus cycle: drive, check combinational outputs at the falling edge,
    // advance the model on the rising edge, then check the fault registers.
    task automatic step(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] s, input logic uns,
                        input logic inj, input logic clr);
        logic        mis, oor, ill, acc, par, evt;
        logic [31:0] exp_rd;
        WE = we; RE = re; ALUOutM = a; WriteDataM = wd; SizeM = s;
        LoadUnsM = uns; ParityInjM = inj; FaultClr = clr;
        mis = (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
        oor = a >= 32'(NB);
        ill = (s == 2'd3);
        acc = (we | re) & (mis | oor | ill);
        par = model_par(re, a, s);
        evt = acc | par;
        exp_rd = model_load(a, s, uns);
        @(negedge CLK);
        last_rd  = ReadDataM;
        last_par = ParityErrM;
        check("rdata",  ReadDataM, exp_rd);
        check("accerr", 32'(AccErrM), 32'(acc));
        check("parerr", 32'(ParityErrM), 32'(par));
        @(posedge CLK);
        if (we && !acc)
            for (int i = 0; i < nbytes(s); i++) begin
                mb[int'(a) + i]   = 8'(wd >> (8 * i));
                mbad[int'(a) + i] = inj;
            end
        if (evt && (!m_fv || clr)) begin
            m_fv = 1; m_fa = a; m_fc = {par, ill, oor, mis}; m_fw = we;
        end else if (clr) begin
            m_fv = 0; m_fa = 0; m_fc = 0; m_fw = 0;
        end
        if (evt && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        #1;
        check("fvalid", 32'(FaultValid), 32'(m_fv));
        check("faddr",  FaultAddr, m_fa);
        check("fcause", 32'(FaultCause), 32'(m_fc));
        check("fwr",    32'(FaultWr), 32'(m_fw));
        check("fcnt",   32'(FaultCnt), 32'(m_cnt));
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [1:0]  s;
        checks = 0; failures = 0;
        rst = 1'b0; WE = 0; RE = 0; ALUOutM = 0; WriteDataM = 0; SizeM = 0;
        LoadUnsM = 0; ParityInjM = 0; FaultClr = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_fvalid", 32'(FaultValid), 32'h0);
        check("rst_faddr",  FaultAddr, 32'h0);
        check("rst_fcause", 32'(FaultCause), 32'h0);
        check("rst_fcnt",   32'(FaultCnt), 32'h0);
        check("rst_rdata",  ReadDataM, 32'h0);
        rst = 1'b1;
        @(posedge CLK); #1;

        // Word store and reads.
        step(1, 0, 32'h10, 32'hDEADBEEF, 2'd2, 0, 0, 0);
        step(0, 1, 32'h10, 0, 2'd2, 0, 0, 0);
        check("tp_word", last_rd, 32'hDEADBEEF);
        step(0, 1, 32'h14, 0, 2'd2, 0, 0, 0);
        check("tp_word_next", last_rd, 32'h0);
        check("tp_nofault", 32'(FaultValid), 32'h0);

        // Byte store and extension.
        step(1, 0, 32'h21, 32'h00000080, 2'd0, 0, 0, 0);
        step(0, 1, 32'h21, 0, 2'd0, 0, 0, 0);
        check("tp_byte_s", last_rd, 32'hFFFFFF80);
        step(0, 1, 32'h21, 0, 2'd0, 1, 0, 0);
        check("tp_byte_u", last_rd, 32'h00000080);
        step(0, 1, 32'h20, 0, 2'd2, 0, 0, 0);
        check("tp_byte_w", last_rd, 32'h00008000);

        // Half store over an existing word.
        step(1, 0, 32'h30, 32'h11223344, 2'd2, 0, 0, 0);
        step(1, 0, 32'h32, 32'h0000ABCD, 2'd1, 0, 0, 0);
        step(0, 1, 32'h30, 0, 2'd2, 0, 0, 0);
        check("tp_half_w", last_rd, 32'hABCD3344);
        step(0, 1, 32'h32, 0, 2'd1, 0, 0, 0);
        check("tp_half_s", last_rd, 32'hFFFFABCD);

        // Faults: misaligned store, out-of-range load, clear plus illegal size.
        step(1, 0, 32'h41, 32'hCAFEF00D, 2'd2, 0, 0, 0);
        check("tp_mis_addr",  FaultAddr, 32'h41);
        check("tp_mis_cause", 32'(FaultCause), 32'h1);
        check("tp_mis_wr",    32'(FaultWr), 32'h1);
        check("tp_mis_cnt",   32'(FaultCnt), 32'h1);
        step(0, 1, 32'h40, 0, 2'd2, 0, 0, 0);
        check("tp_mis_nowr", last_rd, 32'h0);
        step(0, 1, 32'h400, 0, 2'd2, 0, 0, 0);
        check("tp_oor_rd",   last_rd, 32'h0);
        check("tp_oor_cnt",  32'(FaultCnt), 32'h2);
        check("tp_oor_addr", FaultAddr, 32'h41);
        step(0, 1, 32'h8, 0, 2'd3, 0, 0, 1);
        check("tp_clr_valid", 32'(FaultValid), 32'h1);
        check("tp_clr_addr",  FaultAddr, 32'h8);
        check("tp_clr_cause", 32'(FaultCause), 32'h4);

`ifdef DMEM_PARITY_EN
        step(1, 0, 32'h50, 32'h5A, 2'd0, 0, 1, 0);
        step(0, 1, 32'h50, 0, 2'd0, 0, 0, 1);
        check("tp_par_err",   32'(last_par), 32'h1);
        check("tp_par_cause", 32'(FaultCause[3]), 32'h1);
        step(0, 1, 32'h51, 0, 2'd0, 0, 0, 0);
        check("tp_par_clean", 32'(last_par), 32'h0);
`endif

        // Randomised traffic, biased toward aligned, in-range addresses.
        for (int k = 0; k < 500; k++) begin
            s  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0)      a = $urandom;
            else if ($urandom_range(0, 1) == 0)  a = 32'($urandom_range(0, 127));
            else                                 a = 32'($urandom_range(0, NB - 1));
            if (s != 2'd3 && $urandom_range(0, 9) < 7) a = a & ~32'(nbytes(s) - 1);
            wd = $urandom;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd, s,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        // Counter saturation.
        for (int k = 0; k < 260; k++) step(0, 1, 32'h8, 0, 2'd3, 0, 0, 0);
        check("sat_cnt", 32'(FaultCnt), 32'hFF);

        // Reset asserted in the middle of a store.
        step(1, 0, 32'h60, 32'h01020304, 2'd2, 0, 0, 0);
        WE = 1; RE = 0; ALUOutM = 32'h60; WriteDataM = 32'hA5A5A5A5; SizeM = 2'd2;
        FaultClr = 0;
        #2 rst = 1'b0;
        @(posedge CLK); #1;
        WE = 0;
        #2 rst = 1'b1;
        model_reset();
        @(posedge CLK); #1;
        check("rstw_fvalid", 32'(FaultValid), 32'h0);
        check("rstw_faddr",  FaultAddr, 32'h0);
        check("rstw_fcause", 32'(FaultCause), 32'h0);
        check("rstw_fwr",    32'(FaultWr), 32'h0);
        check("rstw_fcnt",   32'(FaultCnt), 32'h0);
        step(0, 1, 32'h60, 0, 2'd2, 0, 0, 0);
        check("rstw_word", last_rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_subword.md
Name: data_mem_subword

Overview:
Parametrised data memory for the MEM stage, replacing the word-only data memory. It takes byte addresses and supports byte, half and word loads and stores with per-lane write masking and sign or zero extension on loads. Misaligned, out-of-range and illegal-size accesses are suppressed and recorded in a sticky fault-capture register with a saturating fault counter. Writes are synchronous; reads are asynchronous, so MEM-stage timing is unchanged.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, >= 4
AW, $clog2(DEPTH), word-index width (derived, not overridden)
CNT_W, 8, fault counter width

Ports:
CLK  in  1  clock
rst  in  1  asynchronous active-low reset
WE  in  1  store enable
RE  in  1  load enable; qualifies fault capture only
ALUOutM  in  32  byte address
WriteDataM  in  32  store data, right-aligned
SizeM  in  2  00 byte, 01 half, 10 word, 11 illegal
LoadUnsM  in  1  1 = zero-extend loads, 0 = sign-extend
ParityInjM  in  1  inverts stored parity on write (used only with DMEM_PARITY_EN)
ReadDataM  out  32  extended load data
AccErrM  out  1  combinational: current access is illegal
ParityErrM  out  1  combinational parity mismatch (0 without the feature)
FaultValid  out  1  sticky fault-captured flag
FaultAddr  out  32  address of the first captured fault
FaultCause  out  4  bit0 misaligned, bit1 out-of-range, bit2 illegal size, bit3 parity
FaultWr  out  1  captured fault was a store
FaultCnt  out  CNT_W  saturating count of faulting accesses
FaultClr  in  1  clears FaultValid, FaultAddr, FaultCause and FaultWr

Behaviour:
- Reset (rst=0, async): all words = 0, FaultValid = 0, FaultAddr = 0, FaultCause = 0, FaultWr = 0, FaultCnt = 0. Combinational outputs follow from the cleared state. Reset mid-write aborts the write.
- idx = ALUOutM[AW+1:2]; lane = ALUOutM[1:0].
- Misaligned: half with lane[0]=1; word with lane != 0.
- Out-of-range: ALUOutM >= 4*DEPTH, meaning any set bit above AW+1.
- Illegal size: SizeM = 11.
- AccErrM = (WE|RE) & (misaligned | out-of-range | illegal size).
- Store, on posedge CLK when WE & !AccErrM:
  - byte: lane L <= WriteDataM[7:0].
  - half: lanes {2*lane[1]+1, 2*lane[1]} <= WriteDataM[15:0].
  - word: all four lanes.
  - Unselected lanes hold their value.
- Load (combinational): the selected byte or half is taken from mem[idx] and extended per LoadUnsM; a word is passed through. ReadDataM = 0 whenever the access is illegal, regardless of RE.
- Read during a write to the same word returns the old data until the clock edge, then the new data.
- Fault capture, on posedge:
  - A faulting event is AccErrM, or ParityErrM & RE.
  - If the event occurs and FaultValid=0, latch ALUOutM, the cause bits, WE, and set FaultValid=1.
  - Later faults do not overwrite the captured one.
  - FaultCnt increments on every faulting event and saturates at all-ones.
- FaultClr and a faulting event in the same cycle: the new fault is captured (FaultValid stays 1). FaultClr never clears FaultCnt; only reset does.

Optional Feature:
DMEM_PARITY_EN:
- Defined:
  - Each word stores 4 even-parity bits, one per lane, cleared to 0 on reset.
  - A store updates the parity of written lanes only; each is inverted if ParityInjM=1.
  - On a legal load with RE=1, ParityErrM=1 if any accessed lane's parity mismatches, and the fault is captured with cause bit3.
- Undefined:
  - No parity storage; ParityErrM tied 0; ParityInjM ignored; cause bit3 is always 0.

Test Plan:
- Reset, then word store 0xDEADBEEF at 0x10 -> word load at 0x10 returns 0xDEADBEEF; load at 0x14 returns 0; FaultValid=0.
- Byte store 0x80 at 0x21, then signed byte load at 0x21 -> 0xFFFFFF80; unsigned -> 0x00000080; word load at 0x20 -> 0x00008000.
- Half store 0xABCD at 0x32 over word 0x11223344 at 0x30 -> word load 0xABCD3344; signed half load at 0x32 -> 0xFFFFABCD.
- Word store at 0x41 -> memory unchanged; AccErrM=1; FaultAddr=0x41, FaultCause=0001, FaultWr=1, FaultCnt=1. Then a load at 0x400 (DEPTH=64) -> ReadDataM=0, FaultCnt=2, FaultAddr still 0x41. Then FaultClr together with a SizeM=11 load at 0x8 -> FaultValid=1, FaultAddr=0x8, FaultCause=0100.
- With DMEM_PARITY_EN: byte store at 0x50 with ParityInjM=1 -> byte load at 0x50 gives ParityErrM=1 and FaultCause bit3=1; byte load at 0x51 gives ParityErrM=0.
- Assert rst during a store with WE=1 -> target word reads 0 afterwards; all fault outputs are 0.
